// File: rtl/soc_pkg.sv
// soc_pkg: SoC-wide constants and shared types.
//  CLK_FREQ_MHZ  core clock frequency in MHz
//  UART_BASE     base address of the UART transmitter (4 KB window)
//  UART_*_OFS    register offsets inside the UART window
//  uart_tx_state_e  serializer state encoding
package soc_pkg;

  localparam int unsigned CLK_FREQ_MHZ = 50;
  localparam logic [31:0] UART_BASE    = 32'h1000_0000;

  localparam logic [11:0] UART_TXDATA_OFS = 12'h000;
  localparam logic [11:0] UART_STATUS_OFS = 12'h004;
  localparam logic [11:0] UART_CTRL_OFS   = 12'h008;

  typedef enum logic [1:0] {
    UTX_IDLE,
    UTX_START,
    UTX_DATA,
    UTX_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/soc_sync_fifo.sv
// soc_sync_fifo: single-clock FIFO with occupancy count.
//  clk, rst    clock, async active-high reset (empties the FIFO)
//  push, wdata write side; a push while full is dropped
//  pop, rdata  read side; rdata shows the head entry (valid when !empty)
//  full, empty, count  occupancy flags and entry count
// Full is judged on pre-pop occupancy, so push+pop on a full FIFO drops the push.
module soc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/soc_uart_tx.sv
// soc_uart_tx: memory-mapped 8N1 UART transmitter.
//  clk, rst              core clock, async active-high reset
//  req_valid/req_ready   bus request handshake (always accepted)
//  req_we/addr/wdata     write enable, byte address, write data
//  rsp_valid/rsp_rdata   response one cycle after an accepted hit; rdata 0 for writes
//  tx_o                  serial line, idle high
//  irq_o                 level interrupt: irq_en && FIFO empty && serializer idle
// Registers: 0x0 TXDATA (W push), 0x4 STATUS, 0x8 CTRL {irq_en, enable}.
module soc_uart_tx
  import soc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_MHZ * 1_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = UART_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
  localparam int BW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] RELOAD = BW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("soc_uart_tx: CLK_FREQ_HZ/BAUD must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("soc_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  // Bus decode
  logic        hit, wr, rd, push;
  logic [11:0] ofs;
  logic        enable, irq_en, overflow;
  logic [31:0] status_word, rdata_d;

  assign req_ready = 1'b1;
  assign ofs  = req_addr[11:0];
  assign hit  = req_valid && (req_addr[31:12] == BASE_ADDR[31:12]);
  assign wr   = hit && req_we;
  assign rd   = hit && !req_we;
  assign push = wr && (ofs == UART_TXDATA_OFS);

  // FIFO
  logic          pop, full, empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  soc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (req_wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Serializer state
  uart_tx_state_e state, state_d;
  logic [BW-1:0]  baud_cnt, baud_d;
  logic [2:0]     bit_cnt, bit_d;
  logic [7:0]     shreg, sh_d;
  logic           tx_d, busy;

  assign busy = (state != UTX_IDLE);

  assign status_word = {20'b0, 4'(fifo_count), 4'b0, overflow, busy, empty, full};

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (ofs)
        UART_STATUS_OFS: rdata_d = status_word;
        UART_CTRL_OFS:   rdata_d = {30'b0, irq_en, enable};
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      rsp_valid <= hit;
      rsp_rdata <= rdata_d;
      if (wr && ofs == UART_CTRL_OFS) {irq_en, enable} <= req_wdata[1:0];
      if (push && full)
        overflow <= 1'b1;
      else if (wr && ofs == UART_STATUS_OFS && req_wdata[3])
        overflow <= 1'b0;
      irq_o <= irq_en && empty && !busy;
    end
  end

  // Next-state: each phase lasts DIV cycles, the counter reloading on every
  // state or bit entry, so a frame is exactly 10*DIV cycles.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt - 1'b1;
    bit_d   = bit_cnt;
    sh_d    = shreg;
    pop     = 1'b0;
    case (state)
      UTX_IDLE: begin
        baud_d = baud_cnt;
        if (enable && !empty) begin
          state_d = UTX_START;
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          baud_d  = RELOAD;
        end
      end
      UTX_START: begin
        if (baud_cnt == '0) begin
          state_d = UTX_DATA;
          baud_d  = RELOAD;
          bit_d   = 3'd0;
        end
      end
      UTX_DATA: begin
        if (baud_cnt == '0) begin
          baud_d = RELOAD;
          sh_d   = shreg >> 1;
          if (bit_cnt == 3'd7) state_d = UTX_STOP;
          else                 bit_d   = bit_cnt + 1'b1;
        end
      end
      UTX_STOP: begin
        if (baud_cnt == '0) begin
          if (enable && !empty) begin
            state_d = UTX_START;
            pop     = 1'b1;
            sh_d    = fifo_rdata;
            baud_d  = RELOAD;
          end else begin
            state_d = UTX_IDLE;
          end
        end
      end
      default: state_d = UTX_IDLE;
    endcase
    // Line level follows the next state so tx_o is a clean flop output.
    case (state_d)
      UTX_START: tx_d = 1'b0;
      UTX_DATA:  tx_d = sh_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UTX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_o     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shreg    <= sh_d;
      tx_o     <= tx_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^req_wdata[31:8];

endmodule
